// File: rtl/rr_arb_stream_mux.sv
// Packet-locked stream mux behind a round-robin arbiter: forwards one whole packet per grant, then pulses reqArb.
// Optional per-channel packet counters on pktCnt are built when RR_ARB_MUX_PKT_CNT_EN is defined.
module rr_arb_stream_mux #(
    parameter int NREQ          = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 2,
    localparam int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            sTvalid,
    input  logic [NREQ*DATA_WIDTH-1:0] sTdata,
    input  logic [NREQ-1:0]            sTlast,
    output logic [NREQ-1:0]            sTready,
    output logic [NREQ-1:0]            reqBus,
    output logic                       reqArb,
    input  logic [NREQ-1:0]            grantBus,
    output logic                       mTvalid,
    output logic                       mTlast,
    output logic [DATA_WIDTH-1:0]      mTdata,
    output logic [IDW-1:0]             mTid,
    input  logic                       mTready,
    output logic                       busy,
    output logic [NREQ*16-1:0]         pktCnt,
    output logic [1:0]                 dbg_state
);

    // Stream handshake: a beat moves on a cycle where valid and ready are both high;
    // valid never waits on ready, and the selected channel's ready is mTready passed straight through.
    typedef enum logic [1:0] {IDLE, XFER, RELEASE, SETTLE} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  sel, sel_nxt;
    logic [3:0]      settle_cnt, settle_cnt_nxt;
    logic [NREQ-1:0] req_q, req_nxt;
    logic            grant_hit;
    logic [IDW-1:0]  grant_idx;
    logic            last_hs;

    // Only a clean one-hot grant on a channel that actually has data starts a packet.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        if ($onehot(grantBus)) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grantBus[i] && sTvalid[i]) begin
                    grant_hit = 1'b1;
                    grant_idx = IDW'(i);
                end
            end
        end
    end

    assign last_hs = (state == XFER) && sTvalid[sel] && mTready && sTlast[sel];

    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        settle_cnt_nxt = settle_cnt;
        req_nxt        = sTvalid;
        case (state)
            IDLE: begin
                if (grant_hit) begin
                    state_nxt = XFER;
                    sel_nxt   = grant_idx;
                end
            end
            XFER: begin
                // Keep requesting the locked channel so the arbiter cannot rotate away mid-packet.
                req_nxt[sel] = 1'b1;
                if (last_hs) state_nxt = RELEASE;
            end
            RELEASE: begin
                settle_cnt_nxt = '0;
                state_nxt      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == 4'(SETTLE_CYCLES - 1)) state_nxt = IDLE;
                else settle_cnt_nxt = settle_cnt + 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            settle_cnt <= '0;
            req_q      <= '0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            settle_cnt <= settle_cnt_nxt;
            req_q      <= req_nxt;
        end
    end

    // Outputs are forced low while rst is held so a reset mid-packet is visible immediately.
    always_comb begin
        sTready = '0;
        mTvalid = 1'b0;
        mTlast  = 1'b0;
        mTdata  = '0;
        mTid    = '0;
        if (!rst && state == XFER) begin
            mTvalid      = sTvalid[sel];
            mTlast       = sTlast[sel];
            mTdata       = sTdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            mTid         = sel;
            sTready[sel] = mTready;
        end
        reqArb = !rst && (state == RELEASE);
        busy   = !rst && (state != IDLE);
        reqBus = rst ? '0 : req_q;
    end

    assign dbg_state = state;

`ifdef RR_ARB_MUX_PKT_CNT_EN
    logic [NREQ*16-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (last_hs) cnt_q[int'(sel)*16 +: 16] <= cnt_q[int'(sel)*16 +: 16] + 16'd1;
    end

    assign pktCnt = cnt_q;
`else
    assign pktCnt = '0;
`endif

endmodule
